seg_arbiter: RTL and testbench

Time-shares the single `seg10` bar-graph display between two value producers: the rotary-encoder counter (requester 0) and a transient overlay source such as a mode or status indicator (requester 1). It sits between the producers and the `seg10` decoder in `top` and owns the decoder's `count` input. It grants the display to one requester at a time, with a guaranteed minimum dwell per grant, round-robin on contention, and a blank display when nobody requests. It runs in the `clk` domain, not the debounce `slow_clk` domain.

---
 rtl/seg_pkg.sv | 15 +
 rtl/seg_arbiter_dwell_timer.sv | 36 +++
 rtl/seg_arbiter.sv | 122 ++++++++++++
 tb/tb_seg_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: definitions shared by the seg10 display path.
//   state_t / ST_*   : arbiter state encoding
//   SEG_VALUE_WIDTH  : width of a bar-graph value. The encoder, seg10 and
//                      seg_arbiter all use this width.
package seg_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_OWN0 = 2'd1;
    localparam state_t ST_OWN1 = 2'd2;

    localparam int SEG_VALUE_WIDTH = 5;

endpackage

// File: rtl/seg_arbiter_dwell_timer.sv
// dwell_timer: saturating cycle counter that measures how long a grant has been held.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high
//   clear   in  : forces the count to 0. Has priority over enable.
//   enable  in  : increments the count. The count stops at hold_cycles-1.
//   expired out : high while the count equals hold_cycles-1
module dwell_timer #(
    parameter int hold_cycles = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(hold_cycles);
    localparam logic [CW-1:0] LAST = CW'(hold_cycles - 1);

    logic [CW-1:0] dwell;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the values present before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell <= '0;
        end else if (clear) begin
            dwell <= '0;
        end else if (enable && dwell != LAST) begin
            dwell <= dwell + 1'b1;
        end
    end

    assign expired = (dwell == LAST);

endmodule

// File: rtl/seg_arbiter.sv
// seg_arbiter: shares the seg10 bar-graph display between two requesters.
//   Requester 0 is the encoder counter. Requester 1 is a transient overlay source.
//   Contention is served round-robin. Each grant has a minimum dwell.
//   The display is blank when no requester is active.
//   clk    in  : system clock
//   reset  in  : synchronous, active-high
//   req    in  : request level per requester
//   value0 in  : display value of requester 0
//   value1 in  : display value of requester 1
//   gnt    out : registered grant. It is one-hot, or 0 when idle.
//   count  out : registered value for seg10. It is 0 when idle.
//   busy   out : high while any grant is active
module seg_arbiter
    import seg_pkg::*;
#(
    parameter int value_width = SEG_VALUE_WIDTH,
    parameter int hold_cycles = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [value_width-1:0] value0,
    input  logic [value_width-1:0] value1,
    output logic [1:0]             gnt,
    output logic [value_width-1:0] count,
    output logic                   busy
);

    state_t                 state;
    state_t                 next_state;
    logic                   last;       // most recently served requester
    logic                   expired;
    logic [1:0]             gnt_next;
    logic [value_width-1:0] count_next;

    // The dwell count restarts on every state entry. It runs only while a grant is held.
    dwell_timer #(
        .hold_cycles(hold_cycles)
    ) u_dwell (
        .clk    (clk),
        .reset  (reset),
        .clear  (next_state != state),
        .enable (state != ST_IDLE),
        .expired(expired)
    );

    // State register. gnt and count are registered from the next state,
    // so they change on the same edge that makes the decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= 1'b1;
            gnt   <= 2'b00;
            count <= '0;
        end else begin
            state <= next_state;
            gnt   <= gnt_next;
            count <= count_next;
            if (next_state == ST_OWN0) begin
                last <= 1'b0;
            end else if (next_state == ST_OWN1) begin
                last <= 1'b1;
            end
        end
    end

    // Next-state logic
    // NOTE: each combinational output gets a default first, so no path
    // through the block can leave a value held and infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                case (req)
                    2'b01:   next_state = ST_OWN0;
                    2'b10:   next_state = ST_OWN1;
                    2'b11:   next_state = last ? ST_OWN0 : ST_OWN1;
                    default: next_state = ST_IDLE;
                endcase
            end
            ST_OWN0: begin
                if (!req[0]) begin
                    // The owner may release early. The display goes straight to the waiter if one exists.
                    next_state = req[1] ? ST_OWN1 : ST_IDLE;
                end else if (req[1] && expired) begin
                    next_state = ST_OWN1;
                end
            end
            ST_OWN1: begin
                if (!req[1]) begin
                    next_state = req[0] ? ST_OWN0 : ST_IDLE;
                end else if (req[0] && expired) begin
                    next_state = ST_OWN0;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic. The owner's value passes through live on every cycle.
    always_comb begin
        gnt_next   = 2'b00;
        count_next = '0;
        case (next_state)
            ST_OWN0: begin
                gnt_next   = 2'b01;
                count_next = value0;
            end
            ST_OWN1: begin
                gnt_next   = 2'b10;
                count_next = value1;
            end
            default: begin
                gnt_next   = 2'b00;
                count_next = '0;
            end
        endcase
    end

    assign busy = |gnt;

endmodule

// File: tb/tb_seg_arbiter.sv
// tb_seg_arbiter: self-checking bench for seg_arbiter with hold_cycles = 4.
// Each stimulus step updates a behavioural model and pushes the expected
// gnt/count/busy values to a scoreboard queue. After the clock edge, the
// expected values are popped and compared with the DUT outputs.
module tb_seg_arbiter;

    localparam int VW   = 5;
    localparam int HOLD = 4;

    typedef struct {
        logic [1:0]    gnt;
        logic [VW-1:0] count;
        logic          busy;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [VW-1:0] value0;
    logic [VW-1:0] value1;
    logic [1:0]    gnt;
    logic [VW-1:0] count;
    logic          busy;

    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    // Model state: m_own is -1 when idle, otherwise the index of the owner.
    int m_own   = -1;
    int m_dwell = 0;
    int m_last  = 1;

    seg_arbiter #(
        .value_width(VW),
        .hold_cycles(HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .value0(value0),
        .value1(value1),
        .gnt   (gnt),
        .count (count),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock edge and return the outputs expected after that edge.
    function automatic exp_t model(input logic r, input logic [1:0] q,
                                   input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        int   nxt;
        if (r) begin
            m_own   = -1;
            m_dwell = 0;
            m_last  = 1;
        end else begin
            if (m_own < 0) begin
                if (q == 2'b01)      nxt = 0;
                else if (q == 2'b10) nxt = 1;
                else if (q == 2'b11) nxt = 1 - m_last;
                else                 nxt = -1;
            end else begin
                int i = m_own;
                int j = 1 - m_own;
                if (!q[i])                           nxt = q[j] ? j : -1;
                else if (q[j] && m_dwell == HOLD-1)  nxt = j;
                else                                 nxt = i;
            end
            if (nxt != m_own) begin
                m_dwell = 0;
                if (nxt >= 0) m_last = nxt;
            end else if (m_own >= 0 && m_dwell < HOLD-1) begin
                m_dwell++;
            end
            m_own = nxt;
        end
        e.gnt   = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
        e.count = (m_own == 0) ? a : (m_own == 1) ? b : '0;
        e.busy  = (m_own >= 0);
        return e;
    endfunction

    task automatic step(input logic r, input logic [1:0] q,
                        input logic [VW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        reset  = r;
        req    = q;
        value0 = a;
        value1 = b;
        sb.push_back(model(r, q, a, b));
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("gnt",   32'(gnt),   32'(e.gnt));
            check("count", 32'(count), 32'(e.count));
            check("busy",  32'(busy),  32'(e.busy));
            check("gnt_not_both", 32'(gnt == 2'b11), 32'd0);
        end
    endtask

    initial begin
        // Reset for 2 cycles with both requests active.
        step(1'b1, 2'b11, 5'd3, 5'd9);
        step(1'b1, 2'b11, 5'd3, 5'd9);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        // Requester 0 wins first after reset, because last is reset to 1.
        step(1'b0, 2'b11, 5'd3, 5'd9);
        check("rel_gnt", 32'(gnt), 32'd1);
        step(1'b0, 2'b00, 5'd3, 5'd9);

        // Single requester with a live value update, then release.
        step(1'b0, 2'b01, 5'd7, 5'd0);
        check("single_gnt", 32'(gnt), 32'd1);
        step(1'b0, 2'b01, 5'd7, 5'd0);
        step(1'b0, 2'b01, 5'd12, 5'd0);
        check("single_live", 32'(count), 32'd12);
        step(1'b0, 2'b00, 5'd12, 5'd0);
        check("single_drop", 32'(count), 32'd0);

        // Sustained contention. Grants alternate every HOLD cycles.
        step(1'b1, 2'b00, 5'd0, 5'd0);
        for (int k = 0; k < 4 * HOLD; k++) begin
            step(1'b0, 2'b11, VW'($urandom_range(31)), VW'($urandom_range(31)));
            check("contend_pattern", 32'(gnt), ((k / HOLD) % 2 == 0) ? 32'd1 : 32'd2);
        end

        // Early release: requester 0 drops at dwell 1. Requester 1 takes over with no gap.
        step(1'b0, 2'b00, 5'd1, 5'd2);
        step(1'b0, 2'b01, 5'd1, 5'd2);
        step(1'b0, 2'b11, 5'd1, 5'd2);
        step(1'b0, 2'b10, 5'd1, 5'd2);
        check("early_handover", 32'(gnt), 32'd2);

        // Reset during a grant (OWN1 at dwell 2).
        step(1'b0, 2'b00, 5'd4, 5'd5);
        step(1'b0, 2'b10, 5'd4, 5'd5);
        step(1'b0, 2'b10, 5'd4, 5'd5);
        step(1'b0, 2'b10, 5'd4, 5'd5);
        step(1'b1, 2'b11, 5'd4, 5'd5);
        check("midrst_idle", 32'(gnt), 32'd0);
        step(1'b0, 2'b11, 5'd4, 5'd5);
        check("midrst_regrant", 32'(gnt), 32'd1);

        // A request pulse one cycle wide gives a grant one cycle long.
        step(1'b0, 2'b00, 5'd6, 5'd8);
        step(1'b0, 2'b10, 5'd6, 5'd8);
        step(1'b0, 2'b00, 5'd6, 5'd8);
        check("pulse_end", 32'(gnt), 32'd0);

        // Random traffic with occasional resets.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(40) == 0), 2'($urandom_range(3)),
                 VW'($urandom_range(31)), VW'($urandom_range(31)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
